// File: rtl/multi_channel_rr_arbiter.sv
// Round-robin allocator of NUM_CHANNELS shared channels to NUM_ROUTERS routers.
// Define ARB_TIMEOUT_EN to add a per-router grant watchdog (TIMEOUT_CYCLES).
module multi_channel_rr_arbiter #(
  parameter int NUM_ROUTERS    = 4,
  parameter int NUM_CHANNELS   = 2,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int CHW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_ROUTERS-1:0]     request,
  input  logic [NUM_ROUTERS-1:0]     done,
  output logic [NUM_ROUTERS-1:0]     grant,
  output logic [NUM_ROUTERS*CHW-1:0] grant_chan,
  output logic [NUM_CHANNELS-1:0]    chan_busy,
  output logic [NUM_ROUTERS-1:0]     timeout
);

  localparam int PW = $clog2(NUM_ROUTERS);

  logic [NUM_ROUTERS-1:0]     grant_q, grant_d;
  logic [NUM_ROUTERS*CHW-1:0] gchan_q, gchan_d;
  logic [NUM_CHANNELS-1:0]    busy_q, busy_d;
  logic [NUM_ROUTERS-1:0]     timeout_q, timeout_d;
  logic [PW-1:0]              ptr_q, ptr_d;
  logic [NUM_ROUTERS-1:0]     expire;
  logic [NUM_ROUTERS-1:0]     rel;
  logic [NUM_ROUTERS-1:0]     elig;
  logic [NUM_CHANNELS-1:0]    free_ch;
  logic                       taken;
  int                         sel;
  int                         idx;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q [NUM_ROUTERS];
  logic [CW-1:0] cnt_d [NUM_ROUTERS];

  always_comb begin
    for (int i = 0; i < NUM_ROUTERS; i++) begin
      expire[i] = grant_q[i] && (cnt_q[i] == CW'(TIMEOUT_CYCLES));
      // Count only while the grant survives this edge untouched.
      if (grant_q[i] && grant_d[i])
        cnt_d[i] = cnt_q[i] + CW'(1);
      else
        cnt_d[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ROUTERS; i++) begin
      if (rst) cnt_q[i] <= '0;
      else     cnt_q[i] <= cnt_d[i];
    end
  end
`else
  assign expire = '0;
`endif

  always_comb begin
    rel       = grant_q & (done | expire);
    timeout_d = grant_q & expire & ~done;
    grant_d   = grant_q & ~rel;
    gchan_d   = gchan_q;
    busy_d    = busy_q;
    ptr_d     = ptr_q;
    taken     = 1'b0;
    sel       = 0;
    idx       = 0;

    for (int i = 0; i < NUM_ROUTERS; i++) begin
      if (rel[i]) begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
          if (int'(gchan_q[i*CHW +: CHW]) == c)
            busy_d[c] = 1'b0;
        end
        gchan_d[i*CHW +: CHW] = '0;
      end
    end

    // Released routers/channels stay ineligible until the next cycle.
    elig    = request & ~grant_q;
    free_ch = ~busy_q;

    for (int k = 0; k < NUM_ROUTERS; k++) begin
      idx   = (int'(ptr_q) + k) % NUM_ROUTERS;
      taken = 1'b0;
      sel   = 0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (!taken && free_ch[c]) begin
          taken = 1'b1;
          sel   = c;
        end
      end
      if (elig[idx] && taken) begin
        grant_d[idx]              = 1'b1;
        gchan_d[idx*CHW +: CHW]   = CHW'(sel);
        busy_d[sel]               = 1'b1;
        free_ch[sel]              = 1'b0;
        ptr_d = PW'((idx + 1) % NUM_ROUTERS);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q   <= '0;
      gchan_q   <= '0;
      busy_q    <= '0;
      timeout_q <= '0;
      ptr_q     <= '0;
    end else begin
      grant_q   <= grant_d;
      gchan_q   <= gchan_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
    end
  end

  assign grant      = grant_q;
  assign grant_chan = gchan_q;
  assign chan_busy  = busy_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_multi_channel_rr_arbiter.sv
// Directed scoreboard bench for multi_channel_rr_arbiter (4 routers, 2 channels).
module tb_multi_channel_rr_arbiter;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] busy;
    logic [3:0] gchan;
    logic [3:0] tmo;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] request = '0;
  logic [3:0] done = '0;
  logic [3:0] grant;
  logic [3:0] grant_chan;
  logic [1:0] chan_busy;
  logic [3:0] timeout;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  multi_channel_rr_arbiter #(
    .NUM_ROUTERS(4),
    .NUM_CHANNELS(2),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .request(request),
    .done(done),
    .grant(grant),
    .grant_chan(grant_chan),
    .chan_busy(chan_busy),
    .timeout(timeout)
  );

  task automatic step(input string tag, input logic r,
                      input logic [3:0] rq, input logic [3:0] dn,
                      input logic [3:0] eg, input logic [1:0] eb,
                      input logic [3:0] ec, input logic [3:0] et);
    exp_t e;
    @(negedge clk);
    rst     = r;
    request = rq;
    done    = dn;
    sb.push_back('{grant: eg, busy: eb, gchan: ec, tmo: et});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    assert (grant === e.grant) else begin
      failures++;
      $error("FAIL %s grant got=%b exp=%b", tag, grant, e.grant);
    end
    checks++;
    assert (chan_busy === e.busy) else begin
      failures++;
      $error("FAIL %s chan_busy got=%b exp=%b", tag, chan_busy, e.busy);
    end
    checks++;
    assert (grant_chan === e.gchan) else begin
      failures++;
      $error("FAIL %s grant_chan got=%b exp=%b", tag, grant_chan, e.gchan);
    end
    checks++;
    assert (timeout === e.tmo) else begin
      failures++;
      $error("FAIL %s timeout got=%b exp=%b", tag, timeout, e.tmo);
    end
  endtask

  task automatic rotation(input string tag);
    step({tag, "_g01"}, 0, 4'b1111, 4'b0000, 4'b0011, 2'b11, 4'b0010, 4'b0000);
    step({tag, "_b1"},  0, 4'b1111, 4'b0011, 4'b0000, 2'b00, 4'b0000, 4'b0000);
    step({tag, "_g23"}, 0, 4'b1111, 4'b0000, 4'b1100, 2'b11, 4'b1000, 4'b0000);
    step({tag, "_b2"},  0, 4'b1111, 4'b1100, 4'b0000, 2'b00, 4'b0000, 4'b0000);
    step({tag, "_g01b"},0, 4'b1111, 4'b0000, 4'b0011, 2'b11, 4'b0010, 4'b0000);
    step({tag, "_rel"}, 0, 4'b0000, 4'b0011, 4'b0000, 2'b00, 4'b0000, 4'b0000);
  endtask

  initial begin
    // Reset held with all requests high.
    step("rst0", 1, 4'b1111, 4'b0000, 4'b0000, 2'b00, 4'b0000, 4'b0000);
    step("rst1", 1, 4'b1111, 4'b0000, 4'b0000, 2'b00, 4'b0000, 4'b0000);
    rotation("rot");

    // ptr=2: router 2 alone gets channel 0, holds with request dropped.
    step("hold_g", 0, 4'b0100, 4'b0000, 4'b0100, 2'b01, 4'b0000, 4'b0000);
    for (int i = 0; i < 10; i++)
      step("hold", 0, 4'b0000, 4'b0000, 4'b0100, 2'b01, 4'b0000, 4'b0000);
    step("hold_rel", 0, 4'b0000, 4'b0100, 4'b0000, 2'b00, 4'b0000, 4'b0000);

    // ptr=3: routers 0,1 take channels 0,1; router 3 waits.
    step("sr_g01", 0, 4'b0011, 4'b0000, 4'b0011, 2'b11, 4'b0010, 4'b0000);
    step("sr_wait", 0, 4'b1011, 4'b0000, 4'b0011, 2'b11, 4'b0010, 4'b0000);
    step("sr_done1", 0, 4'b1011, 4'b0010, 4'b0001, 2'b01, 4'b0000, 4'b0000);
    step("sr_g3", 0, 4'b1011, 4'b0000, 4'b1001, 2'b11, 4'b1000, 4'b0000);
    step("sr_stray", 0, 4'b1011, 4'b0100, 4'b1001, 2'b11, 4'b1000, 4'b0000);
    step("sr_rel", 0, 4'b0000, 4'b1001, 4'b0000, 2'b00, 4'b0000, 4'b0000);

    // ptr=0: router 1 granted channel 0, never signals done.
    step("wd_g", 0, 4'b0010, 4'b0000, 4'b0010, 2'b01, 4'b0000, 4'b0000);
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 8; i++)
      step("wd_hold", 0, 4'b0010, 4'b0000, 4'b0010, 2'b01, 4'b0000, 4'b0000);
    step("wd_exp", 0, 4'b0000, 4'b0000, 4'b0000, 2'b00, 4'b0000, 4'b0010);
    step("wd_after", 0, 4'b0000, 4'b0000, 4'b0000, 2'b00, 4'b0000, 4'b0000);
`else
    for (int i = 0; i < 100; i++)
      step("wd_hold", 0, 4'b0010, 4'b0000, 4'b0010, 2'b01, 4'b0000, 4'b0000);
    step("wd_rel", 0, 4'b0000, 4'b0010, 4'b0000, 2'b00, 4'b0000, 4'b0000);
`endif

    // ptr=2: fill both channels, then reset mid-operation.
    step("mr_g23", 0, 4'b1111, 4'b0000, 4'b1100, 2'b11, 4'b1000, 4'b0000);
    step("mr_rst", 1, 4'b1111, 4'b0000, 4'b0000, 2'b00, 4'b0000, 4'b0000);
    rotation("mr");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog simulation time limit checks=%0d", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/multi_channel_rr_arbiter.md
# multi_channel_rr_arbiter

Parametrised round-robin arbiter that assigns NUM_CHANNELS shared optical wavelength channels to NUM_ROUTERS requesting routers in the ONoC.
- Each grant is held until the owning router signals done.
- Up to NUM_CHANNELS grants may be issued in a single cycle.
- Fairness is kept by a rotating priority pointer.
- It sits between the router injection ports and the waveguide channel allocation logic, and generalises the single-channel masked round-robin arbiter.

## Interface
- NUM_ROUTERS, 4, number of requesting routers (≥2)
- NUM_CHANNELS, 2, number of shared channels (1..NUM_ROUTERS)
- TIMEOUT_CYCLES, 64, grant watchdog limit; used only when ARB_TIMEOUT_EN is defined
- CHW (localparam), max(1, $clog2(NUM_CHANNELS)), channel index width

Ports:
- clk  input  1  clock; all state updates on posedge clk
- rst  input  1  synchronous, active-high reset
- request  input  NUM_ROUTERS  per-router channel request, level-sensitive
- done  input  NUM_ROUTERS  per-router release strobe; acts only while that router is granted
- grant  output  NUM_ROUTERS  router i currently owns a channel
- grant_chan  output  NUM_ROUTERS*CHW  channel owned by router i (slice i); valid only while grant[i]=1
- chan_busy  output  NUM_CHANNELS  channel c currently owned
- timeout  output  NUM_ROUTERS  one-cycle pulse when router i's grant is forcibly revoked

## Operation
- All outputs are registered. On the reset edge: grant=0, grant_chan=0, chan_busy=0, timeout=0, priority pointer ptr=0, watchdog counters=0.
- Eligible router i: request[i]=1 and grant[i]=0.
- Free channel c: chan_busy[c]=0 at the start of the cycle.
- Allocation, each cycle:
  - Scan routers in order ptr, ptr+1, …, ptr+NUM_ROUTERS-1 (mod NUM_ROUTERS).
  - Give each eligible router, in scan order, the lowest-indexed remaining free channel.
  - Stop when free channels run out.
- Pointer update: if at least one grant is issued, ptr becomes (last router granted this cycle + 1) mod NUM_ROUTERS. Otherwise ptr is unchanged.
- Hold: once granted, grant[i] and grant_chan[i] stay constant until release. Dropping request[i] while granted does not release.
- Release: done[i]=1 while grant[i]=1 clears grant[i] and chan_busy[grant_chan[i]] on that edge.
  - A released channel is not reallocated on the same edge; it is free from the next cycle (one-cycle bubble).
  - A router released on an edge is not eligible on that edge. It may be granted again from the next cycle if request stays high and it wins priority.
- done[i] while grant[i]=0 is ignored.
- Simultaneous done from several routers releases all of them on the same edge.
- Invariants checked by the bench:
  - no channel is owned by two routers;
  - popcount(grant) == popcount(chan_busy) ≤ NUM_CHANNELS;
  - grant_chan slices of non-granted routers read 0.

## Timing
- request[i] high at edge k with a free channel and winning priority gives grant[i]=1 after edge k. Latency is one cycle.
- done[i] high at edge k gives grant[i]=0 after edge k. The channel is reallocatable at edge k+1, so a waiting router sees its grant after edge k+1.
- Reset asserted mid-operation drops all grants and all timeout pulses on that edge. There is no release handshake.
- The first allocation after reset deassertion starts the scan from router 0.

## Configuration
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - Each router has a counter of width $clog2(TIMEOUT_CYCLES+1). It clears on grant and increments every cycle grant[i] is held without done[i].
  - When the counter reaches TIMEOUT_CYCLES, grant[i] and its channel are released on the next edge and timeout[i] pulses high for exactly that one cycle.
  - The channel then follows normal release timing (free next cycle).
  - done[i] arriving on the expiry edge counts as a normal release, with no timeout pulse.
- Not defined: no counters are instantiated, timeout is tied to 0, and grants are held indefinitely.

## Test plan
All scenarios use NUM_ROUTERS=4, NUM_CHANNELS=2.
- Reset: assert rst for 2 cycles with request=4'b1111 -> all outputs 0 throughout. The first cycle after release gives grant=4'b0011, grant_chan[0]=0, grant_chan[1]=1, chan_busy=2'b11.
- Rotation: from the reset state hold request=4'b1111 and pulse done on both holders each time they are granted -> grant sequence 0011, 0000 (bubble), 1100, 0000, 0011. Each router is served once per two rounds.
- Hold/request drop: grant router 2 (grant_chan=0), then drop request[2] for 10 cycles -> grant[2] stays 1. done[2]=1 -> grant[2]=0 next edge, chan_busy[0]=0.
- Single release: routers 0,1 hold channels 0,1 and router 3 requests. done[1] at edge k -> grant[1]=0 after k, router 3 granted channel 1 after k+1. Stray done[2] without a grant -> no change.
- Watchdog (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): grant router 1 and never assert done -> timeout[1]=1 for one cycle on the forced release edge, grant[1]=0 and the channel is free the next cycle. Without the macro -> grant held for 100 cycles and timeout stays 0.
- Reset mid-operation: with 2 channels busy assert rst -> grant=0, chan_busy=0, ptr=0 on the same edge. Identical stimulus afterwards reproduces the grant sequence of scenario 2.
